// File: rtl/rbb_pkg.sv
// Shared constants and types for the result batch buffer.
package rbb_pkg;

  localparam int unsigned RBB_AW_DEF        = 4;
  localparam int unsigned RBB_DW_DEF        = 512;
  localparam int unsigned RBB_NUM_LINES_DEF = 16;

  // One-hot state codes
  localparam logic [2:0] RBB_FILL  = 3'b001;
  localparam logic [2:0] RBB_READY = 3'b010;
  localparam logic [2:0] RBB_DRAIN = 3'b100;

  typedef enum logic [2:0] {
    RbbFill  = RBB_FILL,
    RbbReady = RBB_READY,
    RbbDrain = RBB_DRAIN
  } rbb_state_e;

  // True when the output skid can absorb one more read, counting the read already in flight.
  function automatic logic skid_has_room(logic [1:0] cnt, logic pend);
    return (cnt + {1'b0, pend}) < 2'd2;
  endfunction

endpackage

// File: rtl/rbb_if.sv
// Bus bundle of the result batch buffer: PE write side, arbiter handshake, drain stream.
interface rbb_if
  import rbb_pkg::*;
#(
  parameter int unsigned RBB_ADDR_WIDTH = RBB_AW_DEF,
  parameter int unsigned RBB_DATA_WIDTH = RBB_DW_DEF
);

  logic                      WrEn;
  logic [RBB_ADDR_WIDTH-1:0] WrAddr;
  logic [RBB_DATA_WIDTH-1:0] WrDin;
  logic                      batch_end;
  logic                      Full;
  logic                      Empty;
  logic                      request;
  logic                      grant;
  logic                      RdValid;
  logic                      RdReady;
  logic [RBB_DATA_WIDTH-1:0] RdDout;
  logic                      RdLast;
  logic [RBB_ADDR_WIDTH:0]   batch_len;
  logic                      ovf_err;

  // Environment side (PE, arbiter, consumer)
  modport master (
    output WrEn, WrAddr, WrDin, batch_end, grant, RdReady,
    input  Full, Empty, request, RdValid, RdDout, RdLast, batch_len, ovf_err
  );

  // Buffer side
  modport slave (
    input  WrEn, WrAddr, WrDin, batch_end, grant, RdReady,
    output Full, Empty, request, RdValid, RdDout, RdLast, batch_len, ovf_err
  );

endinterface

// File: rtl/rbb_out_skid.sv
// Two-entry valid/ready skid for drained lines (data + last tag).
// Flow-through when empty so a line read from the RAM is visible the cycle it arrives.
module rbb_out_skid #(
  parameter int unsigned Width = 512
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic             out_last_o,
  output logic [1:0]       count_o
);

  logic [Width:0] ent_q [2];
  logic [Width:0] ent_d [2];
  logic [1:0]     cnt_q, cnt_d;
  logic [Width:0] head;
  logic           pop;
  logic           store;

  // Head of queue, or the arriving line when nothing is buffered
  always_comb begin
    out_valid_o = (cnt_q != 2'd0) || in_valid_i;
    if (cnt_q != 2'd0) begin
      head = ent_q[0];
    end else if (in_valid_i) begin
      head = {in_last_i, in_data_i};
    end else begin
      head = '0;
    end
    out_data_o = head[Width-1:0];
    out_last_o = head[Width];
    count_o    = cnt_q;
  end

  // Pop shifts the queue; an arriving line is stored unless it bypasses straight out
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    pop   = out_valid_o && out_ready_i;
    store = in_valid_i && !(pop && (cnt_q == 2'd0));
    if (pop && (cnt_q != 2'd0)) begin
      ent_d[0] = ent_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (store) begin
      ent_d[cnt_d[0]] = {in_last_i, in_data_i};
      cnt_d           = cnt_d + 2'd1;
    end
  end

  // Occupancy register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are qualified by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: rtl/rbb.sv
// Result batch buffer: collects PE result lines, then drains the closed batch in order
// over a valid/ready stream once the host-write arbiter grants the path.
// Optional feature: define RBB_OVF_CHECK_EN for a sticky overflow flag on writes while Full.
module rbb
  import rbb_pkg::*;
#(
  parameter int unsigned RBB_ADDR_WIDTH = RBB_AW_DEF,
  parameter int unsigned RBB_DATA_WIDTH = RBB_DW_DEF,
  parameter int unsigned NUM_LINES      = RBB_NUM_LINES_DEF
) (
  input logic  clk,
  input logic  reset_n,
  rbb_if.slave bus
);

  localparam int unsigned CW = RBB_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] NumLines = CW'(NUM_LINES);

  rbb_state_e    state_q, state_d;
  logic [CW-1:0] wr_count_q, wr_count_d;
  logic [CW-1:0] batch_len_q, batch_len_d;
  logic [CW-1:0] rd_issue_q, rd_issue_d;
  logic [CW-1:0] rd_accept_q, rd_accept_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_last_pend_q, rd_last_pend_d;
  logic [CW-1:0] cnt_next;

  logic                      we;
  logic                      rd_en;
  logic                      pop;
  logic                      sk_valid;
  logic                      sk_last;
  logic [1:0]                sk_cnt;
  logic [RBB_DATA_WIDTH-1:0] sk_data;

  logic [RBB_DATA_WIDTH-1:0] mem_q [2**RBB_ADDR_WIDTH];
  logic [RBB_DATA_WIDTH-1:0] rd_data_q;

  // Write gating, read issue and stream accept
  always_comb begin
    we    = bus.WrEn && (state_q == RbbFill);
    rd_en = (state_q == RbbDrain) && (rd_issue_q < batch_len_q) &&
            skid_has_room(sk_cnt, rd_pend_q);
    pop   = sk_valid && bus.RdReady;
  end

  // Batch state machine and counters
  always_comb begin
    state_d        = state_q;
    wr_count_d     = wr_count_q;
    batch_len_d    = batch_len_q;
    rd_issue_d     = rd_issue_q;
    rd_accept_d    = rd_accept_q;
    cnt_next       = we ? wr_count_q + CW'(1) : wr_count_q;
    rd_pend_d      = rd_en;
    rd_last_pend_d = (rd_issue_q == batch_len_q - CW'(1));
    unique case (state_q)
      RbbFill: begin
        wr_count_d = cnt_next;
        if (we && (wr_count_q == NumLines - CW'(1))) begin
          state_d     = RbbReady;
          batch_len_d = NumLines;
        end else if (bus.batch_end && (cnt_next != '0)) begin
          state_d     = RbbReady;
          batch_len_d = cnt_next;
        end
      end
      RbbReady: begin
        if (bus.grant) begin
          state_d     = RbbDrain;
          rd_issue_d  = '0;
          rd_accept_d = '0;
        end
      end
      RbbDrain: begin
        if (rd_en) begin
          rd_issue_d = rd_issue_q + CW'(1);
        end
        if (pop) begin
          if (rd_accept_q == batch_len_q - CW'(1)) begin
            // Final line accepted: reopen for the next batch
            state_d     = RbbFill;
            wr_count_d  = '0;
            batch_len_d = '0;
            rd_issue_d  = '0;
            rd_accept_d = '0;
          end else begin
            rd_accept_d = rd_accept_q + CW'(1);
          end
        end
      end
      default: state_d = RbbFill;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RbbFill;
      wr_count_q     <= '0;
      batch_len_q    <= '0;
      rd_issue_q     <= '0;
      rd_accept_q    <= '0;
      rd_pend_q      <= 1'b0;
      rd_last_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_count_q     <= wr_count_d;
      batch_len_q    <= batch_len_d;
      rd_issue_q     <= rd_issue_d;
      rd_accept_q    <= rd_accept_d;
      rd_pend_q      <= rd_pend_d;
      rd_last_pend_q <= rd_last_pend_d;
    end
  end

  // Simple dual-port line RAM with registered read (one-cycle latency)
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[bus.WrAddr] <= bus.WrDin;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_issue_q[RBB_ADDR_WIDTH-1:0]];
    end
  end

  rbb_out_skid #(
    .Width (RBB_DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (rd_pend_q),
    .in_data_i   (rd_data_q),
    .in_last_i   (rd_last_pend_q),
    .out_valid_o (sk_valid),
    .out_ready_i (bus.RdReady),
    .out_data_o  (sk_data),
    .out_last_o  (sk_last),
    .count_o     (sk_cnt)
  );

  // Status and stream outputs, all decoded from registers
  always_comb begin
    bus.Full      = (state_q != RbbFill);
    bus.Empty     = (state_q == RbbFill) && (wr_count_q == '0);
    bus.request   = (state_q == RbbReady);
    bus.batch_len = batch_len_q;
    bus.RdValid   = sk_valid;
    bus.RdDout    = sk_data;
    bus.RdLast    = sk_last;
  end

`ifdef RBB_OVF_CHECK_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: any write attempt while the buffer is closed
  always_comb begin
    ovf_d = ovf_q || (bus.WrEn && (state_q != RbbFill));
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf_err = ovf_q;
`else
  assign bus.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_rbb.sv
// Self-checking bench for rbb: a batch-level model predicts every status/stream output each
// cycle, and directed tests pin the model with hand-computed values.
module tb_rbb;
  import rbb_pkg::*;

  localparam int DW = 512;
  localparam int NL = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  rbb_if bus ();

  rbb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Batch-level model: phase 0 collecting, 1 waiting for grant, 2 streaming
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_len = 0;
  int          m_acc = 0;
  int          m_age = 0;
  bit          m_ovf = 1'b0;
  logic [DW-1:0] m_mem [NL];
  logic [DW-1:0] cap_q [$];

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_phase = 0; m_cnt = 0; m_len = 0; m_acc = 0; m_age = 0; m_ovf = 1'b0;
    end else begin
`ifdef RBB_OVF_CHECK_EN
      if (bus.WrEn && m_phase != 0) m_ovf = 1'b1;
`endif
      case (m_phase)
        0: begin
          if (bus.WrEn) begin
            m_mem[bus.WrAddr] = bus.WrDin;
            m_cnt++;
          end
          if (bus.WrEn && m_cnt == NL) begin
            m_phase = 1; m_len = NL;
          end else if (bus.batch_end && m_cnt > 0) begin
            m_phase = 1; m_len = m_cnt;
          end
        end
        1: if (bus.grant) begin
          m_phase = 2; m_acc = 0; m_age = 0;
        end
        default: begin
          // Stream is live from the second drain cycle and never bubbles
          if (m_age >= 1 && bus.RdReady) begin
            if (m_acc == m_len - 1) begin
              m_phase = 0; m_cnt = 0;
            end else begin
              m_acc++;
            end
          end
          m_age++;
        end
      endcase
    end
  end

  // Per-cycle compare against the model, plus capture of accepted lines
  initial forever begin
    bit e_valid;
    @(negedge clk);
    e_valid = (m_phase == 2) && (m_age >= 1);
    chk("full", bus.Full, m_phase != 0);
    chk("empty", bus.Empty, m_phase == 0 && m_cnt == 0);
    chk("request", bus.request, m_phase == 1);
    chk("rd_valid", bus.RdValid, e_valid);
    chk("rd_last", bus.RdLast, e_valid && (m_acc == m_len - 1));
    chk("ovf_err", bus.ovf_err, m_ovf);
    if (e_valid) chk("rd_dout", bus.RdDout, m_mem[m_acc]);
    if (m_phase != 0) chk("batch_len", bus.batch_len, m_len);
    if (reset_n && bus.RdValid && bus.RdReady) cap_q.push_back(bus.RdDout);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.WrEn   = 1'b1;
      bus.WrAddr = 4'(i);
      bus.WrDin  = DW'(base + i);
      cyc();
    end
    bus.WrEn = 1'b0;
  endtask

  task automatic pulse_grant();
    bus.grant = 1'b1;
    cyc();
    bus.grant = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    n = 0;
    while (bus.Full && n < budget) begin
      cyc();
      n++;
    end
    chk({name, "_done"}, bus.Full, 1'b0);
  endtask

  int ncyc;

  initial begin
    bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrDin = '0; bus.batch_end = 1'b0;
    bus.grant = 1'b0; bus.RdReady = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    chk("rst_empty", bus.Empty, 1'b1);
    chk("rst_full", bus.Full, 1'b0);
    chk("rst_rdvalid", bus.RdValid, 1'b0);

    // 1: full batch, back-to-back drain
    fill(16, 0);
    chk("t1_request", bus.request, 1'b1);
    chk("t1_len", bus.batch_len, 16);
    cap_q.delete();
    bus.RdReady = 1'b1;
    pulse_grant();
    wait_done("t1", 40, ncyc);
    chk("t1_cycles", ncyc, 17);
    chk("t1_count", cap_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("t1_line", cap_q[i], i);

    // 2: short batch via batch_end, then batch_end on an empty buffer
    fill(5, 100);
    chk("t2_open", bus.Full, 1'b0);
    bus.batch_end = 1'b1;
    cyc();
    bus.batch_end = 1'b0;
    chk("t2_request", bus.request, 1'b1);
    chk("t2_len", bus.batch_len, 5);
    cap_q.delete();
    pulse_grant();
    wait_done("t2", 40, ncyc);
    chk("t2_count", cap_q.size(), 5);
    chk("t2_first", cap_q[0], 100);
    chk("t2_last", cap_q[4], 104);
    bus.batch_end = 1'b1;
    cyc();
    bus.batch_end = 1'b0;
    cyc();
    chk("t2_be0_full", bus.Full, 1'b0);
    chk("t2_be0_req", bus.request, 1'b0);

    // 3: closing write together with batch_end, drain with stalling consumer
    fill(9, 200);
    bus.WrEn = 1'b1; bus.WrAddr = 4'd9; bus.WrDin = DW'(209); bus.batch_end = 1'b1;
    cyc();
    bus.WrEn = 1'b0; bus.batch_end = 1'b0;
    chk("t3_len", bus.batch_len, 10);
    cap_q.delete();
    bus.RdReady = 1'b0;
    pulse_grant();
    for (int k = 0; k < 80 && bus.Full; k++) begin
      bus.RdReady = (k % 3 == 0);
      cyc();
    end
    bus.RdReady = 1'b1;
    chk("t3_done", bus.Full, 1'b0);
    chk("t3_count", cap_q.size(), 10);
    for (int i = 0; i < 10; i++) chk("t3_line", cap_q[i], 200 + i);

    // 4: writes while closed are dropped
    fill(16, 300);
    cap_q.delete();
    bus.RdReady = 1'b0;
    bus.WrEn = 1'b1; bus.WrAddr = 4'd3; bus.WrDin = DW'(32'hDEAD);
    cyc();
    bus.WrAddr = 4'd5; bus.grant = 1'b1;
    cyc();
    bus.grant = 1'b0; bus.WrAddr = 4'd7;
    cyc();
    bus.WrEn = 1'b0;
    bus.RdReady = 1'b1;
    wait_done("t4", 40, ncyc);
    chk("t4_count", cap_q.size(), 16);
    chk("t4_line3", cap_q[3], 303);
    chk("t4_line5", cap_q[5], 305);
    chk("t4_line7", cap_q[7], 307);
`ifdef RBB_OVF_CHECK_EN
    chk("t4_ovf", bus.ovf_err, 1'b1);
`else
    chk("t4_ovf", bus.ovf_err, 1'b0);
`endif

    // 5: reset in the middle of a drain
    fill(16, 400);
    cap_q.delete();
    pulse_grant();
    repeat (8) cyc();
    chk("t5_accepted", cap_q.size(), 7);
    reset_n = 1'b0;
    #1;
    chk("t5_rdvalid", bus.RdValid, 1'b0);
    chk("t5_request", bus.request, 1'b0);
    chk("t5_empty", bus.Empty, 1'b1);
    chk("t5_full", bus.Full, 1'b0);
    cyc();
    reset_n = 1'b1;
    cyc();
    fill(16, 500);
    cap_q.delete();
    pulse_grant();
    wait_done("t5", 40, ncyc);
    chk("t5_count", cap_q.size(), 16);
    chk("t5_first", cap_q[0], 500);
    chk("t5_last", cap_q[15], 515);

    // 6: grant ignored in FILL; grant-to-valid latency
    pulse_grant();
    chk("t6_fill_full", bus.Full, 1'b0);
    chk("t6_fill_req", bus.request, 1'b0);
    fill(2, 600);
    bus.batch_end = 1'b1;
    cyc();
    bus.batch_end = 1'b0;
    cap_q.delete();
    pulse_grant();
    chk("t6_g1_valid", bus.RdValid, 1'b0);
    cyc();
    chk("t6_g2_valid", bus.RdValid, 1'b1);
    chk("t6_g2_data", bus.RdDout, 600);
    wait_done("t6", 40, ncyc);
    chk("t6_count", cap_q.size(), 2);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
